// File: rtl/pal_cfg_pkg.sv
// rtl/pal_cfg_pkg.sv - PAL geometry, derived fuse-frame sizes and controller state encoding
package pal_cfg_pkg;

  localparam int N_IN  = 4;
  localparam int N_PT  = 15;
  localparam int N_OUT = 5;

  localparam int AND_BITS  = N_PT * 2 * N_IN;
  localparam int OR_BITS   = N_OUT * N_PT;
  localparam int FUSE_BITS = AND_BITS + OR_BITS;
  localparam int CNT_W     = $clog2(FUSE_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/pal_eval_core.sv
// rtl/pal_eval_core.sv - combinational AND/OR plane evaluation of the PAL
module pal_eval_core
  import pal_cfg_pkg::*;
(
  input  logic [AND_BITS-1:0] and_fuse,
  input  logic [OR_BITS-1:0]  or_fuse,
  input  logic [N_IN-1:0]     in_vec,
  output logic [N_OUT-1:0]    out_vec
);

  logic [2*N_IN-1:0] lits;
  logic [N_PT-1:0]   pt;

  for (genvar i = 0; i < N_IN; i++) begin : g_lit
    assign lits[2*i]   = in_vec[i];
    assign lits[2*i+1] = ~in_vec[i];
  end

  // A term with no literal selected is forced low rather than the empty-AND value of 1.
  for (genvar p = 0; p < N_PT; p++) begin : g_pt
    logic [2*N_IN-1:0] sel;
    assign sel   = and_fuse[p*2*N_IN +: 2*N_IN];
    assign pt[p] = (|sel) & (&(~sel | lits));
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_or
    assign out_vec[j] = |(or_fuse[j*N_PT +: N_PT] & pt);
  end

endmodule

// File: rtl/pal_cfg_ctrl.sv
// rtl/pal_cfg_ctrl.sv - PAL fuse-bitstream loader with parity-gated commit and registered evaluation
module pal_cfg_ctrl
  import pal_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  input  logic             eval_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic [N_OUT-1:0] out_vec,
  output logic             out_valid,
  output logic             busy,
  output logic             configured,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FUSE_BITS);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 parity;
  logic [FUSE_BITS-1:0] shadow;
  logic [FUSE_BITS-1:0] active;
  logic [N_OUT-1:0]     eval_out;

  // Frame bit k lands in shadow[k], so AND fuses sit low and OR fuses high.
  pal_eval_core u_core (
    .and_fuse (active[AND_BITS-1:0]),
    .or_fuse  (active[FUSE_BITS-1:AND_BITS]),
    .in_vec   (in_vec),
    .out_vec  (eval_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      parity     <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      configured <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            parity    <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            cnt    <= '0;
            parity <= 1'b0;
          end else if (cfg_valid) begin
            parity <= parity ^ cfg_bit;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state     <= ST_CHECK;
              cfg_ready <= 1'b0;
            end else begin
              shadow[cnt] <= cfg_bit;
            end
          end
        end
        ST_CHECK: begin
          // parity already includes the parity bit, so a good frame leaves it at 0
          if (!parity) begin
            active     <= shadow;
            configured <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= eval_valid;
      if (eval_valid) begin
        out_vec <= eval_out;
      end
    end
  end

endmodule

// File: tb/tb_pal_cfg_ctrl.sv
// tb/tb_pal_cfg_ctrl.sv - directed self-checking bench for pal_cfg_ctrl
module tb_pal_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_ready;
  logic       eval_valid;
  logic [3:0] in_vec;
  logic [4:0] out_vec;
  logic       out_valid;
  logic       busy;
  logic       configured;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  logic [195:0] f2, f2_bad, f4, f5;
  logic         chk_eval;
  logic [4:0]   eval_exp;
  int           eval_bad;

  pal_cfg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .eval_valid (eval_valid),
    .in_vec     (in_vec),
    .out_vec    (out_vec),
    .out_valid  (out_valid),
    .busy       (busy),
    .configured (configured),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic push_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) step();
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    step();
    cfg_valid = 1'b0;
    if (chk_eval && (out_vec !== eval_exp)) eval_bad++;
  endtask

  task automatic eval_once(input logic [3:0] v);
    in_vec     = v;
    eval_valid = 1'b1;
    step();
    eval_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_bit    = 1'b0;
    eval_valid = 1'b0;
    in_vec     = 4'b0000;
    chk_eval   = 1'b0;
    eval_exp   = 5'b00000;
    eval_bad   = 0;

    // map 2: PT0 = in0 & in1, out0 = PT0
    f2 = '0; f2[0] = 1'b1; f2[2] = 1'b1; f2[120] = 1'b1;
    f2[195] = ^f2[194:0];
    f2_bad = f2; f2_bad[195] = ~f2[195];
    // map 4: PT1 = ~in3, out4 = PT1
    f4 = '0; f4[15] = 1'b1; f4[181] = 1'b1;
    f4[195] = ^f4[194:0];
    // map 5: PT14 = in0 & ~in2, out2 = PT14
    f5 = '0; f5[112] = 1'b1; f5[117] = 1'b1; f5[164] = 1'b1;
    f5[195] = ^f5[194:0];

    repeat (3) step();
    chk("rst_out_vec", 32'(out_vec), 32'h0);
    chk("rst_flags", {28'h0, cfg_ready, busy, configured, cfg_err}, 32'h0);
    rst = 1'b0;
    step();

    // 1: unconfigured evaluation
    eval_once(4'b1111);
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_vec", 32'(out_vec), 32'h00);
    chk("t1_cfg", {30'h0, configured, cfg_ready}, 32'h0);
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'h0);

    // 2: good load of map 2
    start_load();
    chk("t2_load_flags", {29'h0, cfg_ready, busy, configured}, 32'b110);
    for (int k = 0; k < 196; k++) push_bit(f2[k], 1'b0);
    chk("t2_check_flags", {29'h0, cfg_ready, busy, configured}, 32'b010);
    step();
    chk("t2_commit_flags", {28'h0, cfg_ready, busy, configured, cfg_err}, 32'b0010);
    eval_once(4'b0001);
    chk("t2_eval_0001", 32'(out_vec), 32'h00);
    eval_once(4'b0011);
    chk("t2_eval_0011", {27'h0, out_valid, out_vec}, {27'h0, 1'b1, 5'b00001});
    in_vec = 4'b0000;
    step();
    chk("t2_hold", {27'h0, out_valid, out_vec}, {27'h0, 1'b0, 5'b00001});

    // 3: same map with parity inverted
    start_load();
    for (int k = 0; k < 196; k++) push_bit(f2_bad[k], 1'b0);
    step();
    chk("t3_err_flags", {29'h0, busy, configured, cfg_err}, 32'b011);
    eval_once(4'b0001);
    chk("t3_eval_0001", 32'(out_vec), 32'h00);
    eval_once(4'b0011);
    chk("t3_eval_0011", 32'(out_vec), 32'h01);

    // 4: load map 4 while evaluating against map 2
    in_vec     = 4'b0011;
    eval_valid = 1'b1;
    eval_exp   = 5'b00001;
    start_load();
    chk("t4_err_cleared", 32'(cfg_err), 32'h0);
    chk_eval = 1'b1;
    eval_bad = 0;
    for (int k = 0; k < 196; k++) push_bit(f4[k], 1'b0);
    chk_eval = 1'b0;
    chk("t4_eval_during_load", 32'(eval_bad), 32'h0);
    step();
    chk("t4_eval_in_check", {30'h0, configured, busy}, 32'b10);
    chk("t4_eval_in_check_vec", 32'(out_vec), 32'h01);
    in_vec = 4'b0000;
    step();
    chk("t4_eval_0000", 32'(out_vec), 32'h10);
    in_vec = 4'b1000;
    step();
    eval_valid = 1'b0;
    chk("t4_eval_1000", 32'(out_vec), 32'h00);
    chk("t4_no_err", 32'(cfg_err), 32'h0);

    // 5: gapped load, restart after 100 bits, then full map 5
    start_load();
    for (int k = 0; k < 100; k++) push_bit(1'($urandom_range(0, 1)), 1'b1);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("t5_restart_ready", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 195; k++) push_bit(f5[k], 1'b1);
    chk("t5_ready_before_last", 32'(cfg_ready), 32'h1);
    push_bit(f5[195], 1'b1);
    chk("t5_ready_after_last", {30'h0, cfg_ready, busy}, 32'b01);
    step();
    chk("t5_commit", {30'h0, configured, cfg_err}, 32'b10);
    eval_once(4'b0001);
    chk("t5_eval_0001", 32'(out_vec), 32'h04);
    eval_once(4'b0101);
    chk("t5_eval_0101", 32'(out_vec), 32'h00);
    eval_once(4'b0000);
    chk("t5_eval_0000", 32'(out_vec), 32'h00);
    eval_once(4'b0011);
    chk("t5_eval_0011", 32'(out_vec), 32'h04);

    // 6: reset during LOAD at bit 150
    start_load();
    for (int k = 0; k < 150; k++) push_bit(f5[k], 1'b0);
    cfg_valid = 1'b1;
    cfg_bit   = f5[150];
    rst       = 1'b1;
    #1;
    chk("t6_rst_flags", {27'h0, out_valid, cfg_ready, busy, configured, cfg_err}, 32'h0);
    chk("t6_rst_out_vec", 32'(out_vec), 32'h0);
    cfg_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    eval_once(4'b0011);
    chk("t6_eval_0011", {27'h0, out_valid, out_vec}, {27'h0, 1'b1, 5'b00000});
    chk("t6_idle_flags", {29'h0, cfg_ready, busy, configured}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
